// File: rtl/lcd_refresh_ctrl_if.sv
// Frame-buffer read port: lcd_refresh_ctrl is the master, FrameBuffer the slave.
interface lcd_refresh_ctrl_if;
    logic [9:0] frame_address;
    logic       send_next_data;
    logic [7:0] frame_data;
    logic       busy;

    modport master (
        output frame_address,
        output send_next_data,
        input  frame_data,
        input  busy
    );

    modport slave (
        input  frame_address,
        input  send_next_data,
        output frame_data,
        output busy
    );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// Streams a 128x64 mono frame from the frame buffer to a dual-chip KS0108-style panel.
// Optional build macro LCD_AUTO_REFRESH_EN: refresh loops continuously after the first start.
module lcd_refresh_ctrl #(
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned E_HALF     = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_refresh,
    lcd_refresh_ctrl_if.master fb,
    output logic [7:0]         lcd_db,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_e,
    output logic               lcd_cs1,
    output logic               lcd_cs2,
    output logic               lcd_rst_n,
    output logic               active,
    output logic               refresh_done
);
    localparam int unsigned StrbLen = 2 * E_HALF;
    localparam int unsigned StrbW   = (StrbLen > 1) ? $clog2(StrbLen) : 1;
    localparam int unsigned RstW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned LatW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        StRstWait,
        StInit,
        StIdle,
        StSetPage,
        StSetCol,
        StFetch,
        StLat,
        StWrite
    } state_e;

    state_e           state_q, state_d;
    logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [StrbW-1:0] strb_cnt_q, strb_cnt_d;
    logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
    logic             init_step_q, init_step_d;
    logic [2:0]       page_q, page_d;
    logic             chip_q, chip_d;
    logic [5:0]       col_q, col_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             send_req;
    logic             strobing;
    logic             strb_last;

    assign strobing  = (state_q == StInit) || (state_q == StSetPage) ||
                       (state_q == StSetCol) || (state_q == StWrite);
    assign strb_last = strobing && (strb_cnt_q == StrbW'(StrbLen - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRstWait;
            rst_cnt_q   <= '0;
            strb_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            init_step_q <= 1'b0;
            page_q      <= '0;
            chip_q      <= 1'b0;
            col_q       <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            strb_cnt_q  <= strb_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            init_step_q <= init_step_d;
            page_q      <= page_d;
            chip_q      <= chip_d;
            col_q       <= col_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        init_step_d = init_step_q;
        page_d      = page_q;
        chip_d      = chip_q;
        col_d       = col_q;
        data_d      = data_q;
        done_d      = 1'b0;
        send_req    = 1'b0;
        // Strobe phase counter runs only inside strobing states and restarts per strobe
        strb_cnt_d  = strobing ? (strb_last ? '0 : strb_cnt_q + StrbW'(1)) : '0;

        case (state_q)
            StRstWait: begin
                if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
                    rst_cnt_d = '0;
                    state_d   = StInit;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstW'(1);
                end
            end
            StInit: begin
                if (strb_last) begin
                    init_step_d = ~init_step_q;
                    if (init_step_q) state_d = StIdle;
                end
            end
            StIdle: begin
                if (start_refresh) begin
                    page_d  = '0;
                    chip_d  = 1'b0;
                    col_d   = '0;
                    state_d = StSetPage;
                end
            end
            StSetPage: if (strb_last) state_d = StSetCol;
            StSetCol:  if (strb_last) state_d = StFetch;
            StFetch: begin
                if (!fb.busy) begin
                    send_req  = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = StLat;
                end
            end
            StLat: begin
                // busy is ignored here: an issued request always completes
                if (lat_cnt_q == LatW'(RD_LAT - 1)) begin
                    data_d  = fb.frame_data;
                    state_d = StWrite;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StWrite: begin
                if (strb_last) begin
                    if (col_q != 6'd63) begin
                        col_d   = col_q + 6'd1;
                        state_d = StFetch;
                    end else if (!chip_q) begin
                        chip_d  = 1'b1;
                        col_d   = '0;
                        state_d = StSetPage;
                    end else if (page_q != 3'd7) begin
                        chip_d  = 1'b0;
                        col_d   = '0;
                        page_d  = page_q + 3'd1;
                        state_d = StSetPage;
                    end else begin
                        chip_d  = 1'b0;
                        col_d   = '0;
                        page_d  = '0;
                        done_d  = 1'b1;
`ifdef LCD_AUTO_REFRESH_EN
                        state_d = StSetPage;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
            default: state_d = StRstWait;
        endcase
    end

    always_comb begin
        case (state_q)
            StInit:    lcd_db = init_step_q ? 8'hC0 : 8'h3F;
            StSetPage: lcd_db = {5'b10111, page_q};
            StSetCol:  lcd_db = 8'h40;
            StWrite:   lcd_db = data_q;
            default:   lcd_db = 8'h00;
        endcase
    end

    assign lcd_rs    = (state_q == StWrite);
    assign lcd_rw    = 1'b0;
    assign lcd_e     = strobing && (strb_cnt_q >= StrbW'(E_HALF));
    assign lcd_cs1   = strobing && ((state_q == StInit) || !chip_q);
    assign lcd_cs2   = strobing && ((state_q == StInit) || chip_q);
    assign lcd_rst_n = (state_q != StRstWait);
    assign active    = (state_q == StSetPage) || (state_q == StSetCol) ||
                       (state_q == StFetch) || (state_q == StLat) || (state_q == StWrite);
    assign refresh_done = done_q;

    assign fb.send_next_data = send_req;
    assign fb.frame_address  = {page_q, chip_q, col_q};
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl; frame-buffer model returns frame_address[7:0].
module tb_lcd_refresh_ctrl;
    localparam int EHalf = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_refresh = 1'b0;
    logic [7:0] lcd_db;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_cs1, lcd_cs2, lcd_rst_n, active, refresh_done;

    lcd_refresh_ctrl_if fb_if ();

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(
        .RST_CYCLES(16),
        .E_HALF    (EHalf),
        .RD_LAT    (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_refresh(start_refresh),
        .fb           (fb_if),
        .lcd_db       (lcd_db),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .lcd_cs1      (lcd_cs1),
        .lcd_cs2      (lcd_cs2),
        .lcd_rst_n    (lcd_rst_n),
        .active       (active),
        .refresh_done (refresh_done)
    );

    // Frame buffer: one-cycle read latency
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) fb_if.frame_data <= 8'h00;
        else if (fb_if.send_next_data) fb_if.frame_data <= fb_if.frame_address[7:0];
    end

    typedef struct {
        logic [7:0] db;
        logic       rs;
        logic       cs1;
        logic       cs2;
        int         t;
    } strobe_t;

    strobe_t slog[$];
    int      done_t[$];
    int      cyc = 0;
    int      req_cnt = 0, addr_err = 0, send_busy = 0;
    int      e_hi_len = 0, e_hi_bad = 0, act_low = 0;
    logic    e_prev = 1'b0, mon_act = 1'b0;
    int      checks = 0, failures = 0;
    int      t0 = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fb_if.send_next_data) begin
            if (fb_if.busy) send_busy++;
            if (fb_if.frame_address !== 10'(req_cnt)) addr_err++;
            req_cnt++;
        end
        if (lcd_e && !e_prev) slog.push_back('{lcd_db, lcd_rs, lcd_cs1, lcd_cs2, cyc});
        if (lcd_e) e_hi_len++;
        else if (e_prev) begin
            if (e_hi_len != EHalf) e_hi_bad++;
            e_hi_len = 0;
        end
        e_prev = lcd_e;
        if (refresh_done) done_t.push_back(cyc);
        if (mon_act && !active) act_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        slog.delete();
        done_t.delete();
        req_cnt   = 0;
        addr_err  = 0;
        send_busy = 0;
        e_hi_bad  = 0;
        e_hi_len  = 0;
        act_low   = 0;
    endtask

    task automatic check_strobe(input string tag, input int idx, input logic [10:0] exp);
        if (idx < slog.size())
            check(tag, {slog[idx].db, slog[idx].rs, slog[idx].cs1, slog[idx].cs2}, exp);
        else
            check({tag, "_missing"}, slog.size(), idx + 1);
    endtask

    task automatic wait_req(input int n, input string tag);
        int k = 0;
        while (req_cnt < n && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, (req_cnt >= n), 1);
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_t.size() < n && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, (done_t.size() >= n), 1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start_refresh = 1'b1;
        @(posedge clk);
        #1 start_refresh = 1'b0;
        t0 = cyc;
    endtask

    // Release reset, time the panel reset, verify init strobes and that early starts are dropped
    task automatic reset_release(input string tag);
        int n = 0;
        slog.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            start_refresh = (n == 5);
            if (lcd_rst_n) break;
        end
        start_refresh = 1'b0;
        check({tag, "_rst_len"}, n, 16);
        begin
            int k = 0;
            while (slog.size() < 2 && k < 200) begin
                @(negedge clk);
                #1;
                k++;
            end
        end
        check_strobe({tag, "_cmd_on"}, 0, {8'h3F, 3'b011});
        check_strobe({tag, "_cmd_start"}, 1, {8'hC0, 3'b011});
        if (slog.size() >= 2) check({tag, "_spacing"}, slog[1].t - slog[0].t, 2 * EHalf);
        repeat (12) @(negedge clk);
        check({tag, "_idle"}, {active, lcd_cs1, lcd_cs2, 24'(slog.size())}, {3'b000, 24'd2});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_panel"}, {lcd_rst_n, lcd_e, lcd_rs, lcd_rw, lcd_cs1, lcd_cs2}, 0);
        check({tag, "_ctrl"}, {fb_if.send_next_data, active, refresh_done}, 0);
        check({tag, "_bus"}, {lcd_db, fb_if.frame_address}, 0);
    endtask

    initial begin
        fb_if.busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset_release("init1");

        // Frame A: busy held low
        clear_logs();
        pulse_start();
        @(negedge clk);
        check("a_active_rise", active, 1);
        mon_act = 1'b1;
        wait_done(1, "a_done_seen");
        if (done_t.size() >= 1) check("a_frame_cycles", done_t[0] - t0, 10496);
        check("a_req_count", req_cnt, 1024);
        check("a_addr_order", addr_err, 0);
        check("a_strobe_count", slog.size(), 1056);
        check_strobe("a_page0", 0, {8'hB8, 3'b010});
        check_strobe("a_col0", 1, {8'h40, 3'b010});
        check_strobe("a_data0", 2, {8'h00, 3'b110});
        check_strobe("a_data63", 65, {8'h3F, 3'b110});
        check_strobe("a_chip2_page", 66, {8'hB8, 3'b001});
        check_strobe("a_chip2_col", 67, {8'h40, 3'b001});
        check_strobe("a_chip2_data64", 68, {8'h40, 3'b101});
        check_strobe("a_page7_chip2", 990, {8'hBF, 3'b001});
        check_strobe("a_last_data", 1055, {8'hFF, 3'b101});
        if (slog.size() >= 4) begin
            check("a_cmd_spacing", slog[1].t - slog[0].t, 2 * EHalf);
            check("a_data_spacing", slog[3].t - slog[2].t, 2 + 2 * EHalf);
        end
        check("a_e_high_len", e_hi_bad, 0);

`ifdef LCD_AUTO_REFRESH_EN
        check("auto_active_at_done", active, 1);
        wait_done(2, "auto_done2_seen");
        if (done_t.size() >= 2) check("auto_period", done_t[1] - done_t[0], 10496);
        check("auto_active_held", act_low, 0);
        mon_act = 1'b0;
        repeat (37) @(negedge clk);
`else
        mon_act = 1'b0;
        check("a_active_fall", active, 0);
        repeat (5) @(negedge clk);
        check("a_idle_cs", {active, lcd_cs1, lcd_cs2}, 0);

        // Frame B: busy stall at address 300, start_refresh mid-frame
        clear_logs();
        pulse_start();
        wait_req(300, "b_req299_seen");
        @(posedge clk);
        #1 fb_if.busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 fb_if.busy = 1'b0;
        @(negedge clk);
        check("b_req_after_busy", {fb_if.send_next_data, fb_if.frame_address}, {1'b1, 10'd300});
        wait_req(501, "b_req500_seen");
        pulse_start();
        wait_done(1, "b_done_seen");
        repeat (50) @(negedge clk);
        check("b_single_done", done_t.size(), 1);
        check("b_active_low", active, 0);
        check("b_no_req_while_busy", send_busy, 0);
        check("b_req_count", req_cnt, 1024);
        check("b_addr_order", addr_err, 0);
        check_strobe("b_data299", 309, {8'h2B, 3'b110});
        check_strobe("b_data300", 310, {8'h2C, 3'b110});

        // Frame C: reset mid-frame
        clear_logs();
        pulse_start();
        wait_req(701, "c_req700_seen");
`endif
        #2 reset_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(posedge clk);
        reset_release("init2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_refresh_ctrl.md
# lcd_refresh_ctrl

Display-side reader for the GPU frame buffer. It fetches the 128x64 monochrome frame (1024 bytes, 8 pages x 128 columns) byte by byte over the frame buffer's read port (`frame_address`, `send_next_data`, `frame_data`, `busy`). It streams each byte to a dual-chip KS0108-style panel: chip 1 holds columns 0-63 and chip 2 holds columns 64-127. It sits between `FrameBuffer` and the panel pins and owns panel reset, panel init and the page/column command sequencing.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `lcd_rst_n` is held low after reset release.
- `E_HALF`, 4: cycles per half of an enable strobe. Minimum 1.
- `RD_LAT`, 1: cycles from `send_next_data` high to `frame_data` valid. Minimum 1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_refresh`  in  1  one-cycle pulse that starts a full-frame refresh.
- `busy`  in  1  frame buffer busy; no new read may be issued while it is high.
- `frame_data`  in  8  byte read from the frame buffer; bit 0 is the top row of the page.
- `send_next_data`  out  1  one-cycle read request.
- `frame_address`  out  10  read address `{page[2:0], column[6:0]}`.
- `lcd_db`  out  8  panel data bus.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_rw`  out  1  held at 0 (write only).
- `lcd_e`  out  1  panel enable strobe.
- `lcd_cs1`, `lcd_cs2`  out  1 each  active-high chip selects.
- `lcd_rst_n`  out  1  panel reset.
- `active`  out  1  high while a refresh is in progress.
- `refresh_done`  out  1  one-cycle pulse when the frame is complete.

## Operation
States:
- **RST_WAIT**: hold `lcd_rst_n` low for `RST_CYCLES`, then drive it high and go to INIT.
- **INIT**:
  - Assert both chip selects.
  - Write command 0x3F (display on), then 0xC0 (start line 0).
  - Go to IDLE.
- **IDLE**: on `start_refresh`, clear page, column and chip, set `active`, and go to SET_PAGE.
- **SET_PAGE**: write command 0xB8|page to the current chip, then go to SET_COL.
- **SET_COL**: write command 0x40 (Y address 0), then go to FETCH.
- **FETCH**:
  - Wait while `busy` is high.
  - Then pulse `send_next_data` for one cycle with `frame_address = {page, chip, col[5:0]}`.
  - Capture `frame_data` exactly `RD_LAT` cycles later.
  - Go to WRITE.
- **WRITE**: write the captured byte with `lcd_rs` = 1.
  - If col < 63: increment col and go to FETCH.
  - Else if chip = 0: set chip to 1, col to 0, and go to SET_PAGE.
  - Else if page < 7: set chip to 0, increment page, and go to SET_PAGE.
  - Else: go to DONE.
- **DONE**: pulse `refresh_done`, clear `active`, and go to IDLE.

Write strobe, common to every command and data write:
- `lcd_db`, `lcd_rs` and the chip select are set at strobe start and held for the whole strobe.
- `lcd_e` is low for `E_HALF` cycles, then high for `E_HALF` cycles.
- The next state is entered the cycle after the strobe ends.
- Chip select follows the chip counter: `lcd_cs1` for chip 0, `lcd_cs2` for chip 1. Outside INIT, exactly one is high during a strobe.
- Both chip selects are low in IDLE.

Boundary behaviour:
- `start_refresh` while `active` or before INIT completes: ignored; it is not queued.
- `busy` rising after a request has issued: does not cancel that request; data is still captured at `RD_LAT`.
- `busy` only gates new requests.
- Address wraps only at frame end. The 7-bit column is formed as `{chip, col[5:0]}`; the page counter is 3 bits.
- `reset_n` low mid-frame: all state is cleared asynchronously and the sequence restarts from RST_WAIT, including panel reset and init.

## Timing
Reset values:
- `lcd_rst_n`, `lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_cs1`, `lcd_cs2`, `send_next_data`, `active`, `refresh_done`: 0.
- `lcd_db`, `frame_address`: 0.

Cycle counts:
- One write strobe = 2·`E_HALF` cycles.
- Data byte with `busy` low = 1 + `RD_LAT` + 2·`E_HALF` cycles.
- Full frame: 16 SET_PAGE/SET_COL pairs (32 command strobes) plus 1024 data bytes. With defaults this is 32·8 + 1024·10 = 10496 cycles from `start_refresh` to `refresh_done`.
- `active` rises the cycle after `start_refresh` and falls with the `refresh_done` pulse.

## Configuration
- `LCD_AUTO_REFRESH_EN` defined: DONE returns directly to SET_PAGE with counters cleared, so refresh runs continuously. `refresh_done` still pulses once per frame, `active` stays high, and `start_refresh` is ignored.
- `LCD_AUTO_REFRESH_EN` undefined: refresh runs only on `start_refresh`, as described above.

## Test plan
- Reset release -> `lcd_rst_n` low for 16 cycles. Then two strobes with both chip selects high, `lcd_rs` = 0, `lcd_db` 0x3F then 0xC0.
- `start_refresh` with the frame-buffer model returning `frame_address[7:0]` -> first strobes are 0xB8 then 0x40 on CS1. First data write is 0x00 and the 64th is 0x3F. Chip 2 then starts with 0xB8, 0x40 and `frame_address` 64.
- Full frame, `busy` tied low -> 1024 requests with addresses 0..1023 in order. `refresh_done` arrives 10496 cycles after `start_refresh` and the last data strobe is on CS2.
- Hold `busy` high 20 cycles during FETCH of address 300 -> no `send_next_data` while `busy` is high. The request issues the cycle after `busy` falls and the correct byte is written.
- `start_refresh` pulsed at frame address 500 -> ignored; exactly one `refresh_done`. Then pull `reset_n` low at address 700 -> all outputs return to reset values immediately and the RST_WAIT/INIT sequence repeats.
- With `LCD_AUTO_REFRESH_EN` -> after one `start_refresh`, two consecutive `refresh_done` pulses 10496 cycles apart and `active` never drops.
